// File: rtl/product_accumulator.sv
// Purpose: sums a programmed number of signed products into a wide accumulator (MAC back end); optional clamp-on-overflow via PRODUCT_ACC_SATURATE_EN.
// Latency: acc_valid rises 1 cycle after the last accepted product (1 cycle after start when len==0).
// Backpressure: p_ready only in ACCUM; acc_out/acc_valid held stable in DONE until acc_ready.
module product_accumulator #(
    parameter int P_W   = 64,
    parameter int ACC_W = 72,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic [P_W-1:0]   p_in,
    input  logic             p_valid,
    output logic             p_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic             acc_valid,
    input  logic             acc_ready,
    output logic             busy,
    output logic             overflow
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

`ifdef PRODUCT_ACC_SATURATE_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    logic [1:0]       state;
    logic [LEN_W-1:0] count;
    logic [ACC_W-1:0] p_ext;
    logic [ACC_W-1:0] sum;
    logic [ACC_W-1:0] acc_next;
    logic             add_ovf;
    logic             xfer;

    // Sign-extend the product to the accumulator width and form the raw sum.
    assign p_ext   = ACC_W'($signed(p_in));
    assign sum     = acc_out + p_ext;
    // Overflow: operands agree in sign but the result does not.
    assign add_ovf = (acc_out[ACC_W-1] == p_ext[ACC_W-1]) &&
                     (sum[ACC_W-1] != acc_out[ACC_W-1]);
    assign xfer    = p_valid && p_ready;

    // Next accumulator value: wrap by default, clamp toward the operand sign when saturating.
    always_comb begin
        acc_next = sum;
`ifdef PRODUCT_ACC_SATURATE_EN
        if (add_ovf) begin
            acc_next = acc_out[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
`endif
    end

    // Sequence control FSM; every output is a register updated here.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            count     <= '0;
            acc_out   <= '0;
            acc_valid <= 1'b0;
            p_ready   <= 1'b0;
            busy      <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        acc_out  <= '0;
                        overflow <= 1'b0;
                        count    <= len;
                        busy     <= 1'b1;
                        if (len != '0) begin
                            state   <= S_ACCUM;
                            p_ready <= 1'b1;
                        end else begin
                            // Empty sequence: report a zero sum without consuming anything.
                            state     <= S_DONE;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                S_ACCUM: begin
                    if (xfer) begin
                        acc_out <= acc_next;
                        count   <= count - LEN_W'(1);
                        if (add_ovf) begin
                            overflow <= 1'b1;
                        end
                        if (count == LEN_W'(1)) begin
                            state     <= S_DONE;
                            p_ready   <= 1'b0;
                            acc_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Result held until the sink takes it; start is ignored here.
                    if (acc_ready) begin
                        state     <= S_IDLE;
                        acc_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    acc_valid <= 1'b0;
                    p_ready   <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
module tb_product_accumulator;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  len;
    logic [63:0] p_in;
    logic        p_valid;
    logic        acc_ready;

    logic        p_ready;
    logic [71:0] acc_out;
    logic        acc_valid;
    logic        busy;
    logic        overflow;

    logic        p_ready64;
    logic [63:0] acc_out64;
    logic        acc_valid64;
    logic        busy64;
    logic        overflow64;

    int total = 0;
    int bad   = 0;
    int xfer_cnt = 0;

    product_accumulator #(.P_W(64), .ACC_W(72), .LEN_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready),
        .acc_out(acc_out), .acc_valid(acc_valid), .acc_ready(acc_ready),
        .busy(busy), .overflow(overflow)
    );

    // Narrow-accumulator instance sharing all stimulus, used for the overflow case.
    product_accumulator #(.P_W(64), .ACC_W(64), .LEN_W(8)) u_dut64 (
        .clk(clk), .rst(rst), .start(start), .len(len),
        .p_in(p_in), .p_valid(p_valid), .p_ready(p_ready64),
        .acc_out(acc_out64), .acc_valid(acc_valid64), .acc_ready(acc_ready),
        .busy(busy64), .overflow(overflow64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count accepted products on the main instance.
    always @(posedge clk) begin
        if (rst && p_valid && p_ready) xfer_cnt <= xfer_cnt + 1;
    end

    // Present one product after 'gap' idle cycles and hold it until accepted (bounded).
    task automatic send(input logic [63:0] v, input int gap);
        int c0;
        int n;
        repeat (gap) @(negedge clk);
        p_in = v;
        p_valid = 1'b1;
        c0 = xfer_cnt;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (xfer_cnt == c0 && n < 20);
        if (xfer_cnt == c0) begin
            total++; bad++;
            $display("FAIL send_timeout: product %h not accepted within %0d cycles", v, n);
        end
        p_valid = 1'b0;
    endtask

    task automatic pulse_start(input logic [7:0] l);
        start = 1'b1;
        len = l;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic handshake();
        acc_ready = 1'b1;
        @(negedge clk);
        acc_ready = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        total++; if (acc_out !== 72'd0)  begin bad++; $display("FAIL reset_acc_out: got %h want 0", acc_out); end
        total++; if (acc_valid !== 1'b0) begin bad++; $display("FAIL reset_acc_valid: got %b want 0", acc_valid); end
        total++; if (p_ready !== 1'b0)   begin bad++; $display("FAIL reset_p_ready: got %b want 0", p_ready); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
        total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic();
        int c0;
        c0 = xfer_cnt;
        pulse_start(8'd4);
        total++; if (p_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL basic_enter_accum: p_ready=%b busy=%b want 1 1", p_ready, busy); end
        send(64'd1500, 0);
        send(64'd2064, 0);
        send(64'hFFFFFFFFFFFFFEA7, 0);
        send(64'hFFFFFFFFFFFFFD12, 0);
        total++; if (acc_valid !== 1'b1) begin bad++; $display("FAIL basic_valid_latency: acc_valid=%b want 1", acc_valid); end
        total++; if (acc_out !== 72'd2469) begin bad++; $display("FAIL basic_sum: got %h want 9a5", acc_out); end
        total++; if (overflow !== 1'b0 || p_ready !== 1'b0) begin bad++; $display("FAIL basic_flags: overflow=%b p_ready=%b want 0 0", overflow, p_ready); end
        total++; if (xfer_cnt - c0 != 4) begin bad++; $display("FAIL basic_xfers: got %0d want 4", xfer_cnt - c0); end
        handshake();
        total++; if (acc_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL basic_release: acc_valid=%b busy=%b want 0 0", acc_valid, busy); end
    endtask

    task automatic test_gaps();
        int c0;
        c0 = xfer_cnt;
        pulse_start(8'd4);
        send(64'd1500, 0);
        send(64'd2064, 2);
        send(64'hFFFFFFFFFFFFFEA7, 3);
        send(64'hFFFFFFFFFFFFFD12, 1);
        // Extra product offered while the result waits: must not be taken.
        p_in = 64'd999;
        p_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (acc_valid !== 1'b1 || acc_out !== 72'd2469) begin
                bad++; $display("FAIL gaps_hold[%0d]: acc_valid=%b acc_out=%h want 1 9a5", i, acc_valid, acc_out);
            end
            @(negedge clk);
        end
        p_valid = 1'b0;
        total++; if (xfer_cnt - c0 != 4) begin bad++; $display("FAIL gaps_xfers: got %0d want 4", xfer_cnt - c0); end
        handshake();
        total++; if (acc_valid !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL gaps_release: acc_valid=%b busy=%b want 0 0", acc_valid, busy); end
    endtask

    task automatic test_len_zero();
        int c0;
        c0 = xfer_cnt;
        p_in = 64'd77;
        p_valid = 1'b1;
        pulse_start(8'd0);
        total++; if (acc_valid !== 1'b1 || acc_out !== 72'd0) begin bad++; $display("FAIL len0_result: acc_valid=%b acc_out=%h want 1 0", acc_valid, acc_out); end
        total++; if (p_ready !== 1'b0) begin bad++; $display("FAIL len0_p_ready: got %b want 0", p_ready); end
        handshake();
        p_valid = 1'b0;
        total++; if (xfer_cnt != c0) begin bad++; $display("FAIL len0_xfers: got %0d want 0", xfer_cnt - c0); end
    endtask

    task automatic test_overflow();
        logic [63:0] exp64;
`ifdef PRODUCT_ACC_SATURATE_EN
        exp64 = 64'h7FFFFFFFFFFFFFFF;
`else
        exp64 = 64'h8000000000000000;
`endif
        pulse_start(8'd2);
        send(64'h7FFFFFFFFFFFFFFF, 0);
        send(64'd1, 0);
        total++; if (acc_out64 !== exp64) begin bad++; $display("FAIL ovf64_sum: got %h want %h", acc_out64, exp64); end
        total++; if (overflow64 !== 1'b1) begin bad++; $display("FAIL ovf64_flag: got %b want 1", overflow64); end
        total++; if (acc_out !== 72'h008000000000000000 || overflow !== 1'b0) begin bad++; $display("FAIL ovf72_guard: acc_out=%h overflow=%b want 008000000000000000 0", acc_out, overflow); end
        handshake();
        // Sticky until the next accepted start clears it.
        total++; if (overflow64 !== 1'b1) begin bad++; $display("FAIL ovf64_sticky: got %b want 1", overflow64); end
    endtask

    task automatic test_reset_mid();
        pulse_start(8'd3);
        send(64'd100, 0);
        rst = 1'b0;
        @(negedge clk);
        total++; if (acc_out !== 72'd0 || acc_valid !== 1'b0 || p_ready !== 1'b0 || busy !== 1'b0 || overflow !== 1'b0) begin
            bad++; $display("FAIL midreset_outputs: acc_out=%h acc_valid=%b p_ready=%b busy=%b overflow=%b want all 0", acc_out, acc_valid, p_ready, busy, overflow);
        end
        total++; if (overflow64 !== 1'b0) begin bad++; $display("FAIL midreset_ovf64: got %b want 0", overflow64); end
        rst = 1'b1;
        @(negedge clk);
        pulse_start(8'd1);
        send(64'd2500, 0);
        total++; if (acc_valid !== 1'b1 || acc_out !== 72'd2500 || overflow !== 1'b0) begin
            bad++; $display("FAIL midreset_restart: acc_valid=%b acc_out=%h overflow=%b want 1 9c4 0", acc_valid, acc_out, overflow);
        end
        handshake();
    endtask

    task automatic test_start_ignored();
        pulse_start(8'd2);
        send(64'd10, 0);
        start = 1'b1;
        len = 8'd7;
        @(negedge clk);
        start = 1'b0;
        total++; if (p_ready !== 1'b1 || acc_out !== 72'd10) begin bad++; $display("FAIL ign_accum: p_ready=%b acc_out=%h want 1 a", p_ready, acc_out); end
        send(64'd20, 0);
        total++; if (acc_valid !== 1'b1 || acc_out !== 72'd30) begin bad++; $display("FAIL ign_count: acc_valid=%b acc_out=%h want 1 1e", acc_valid, acc_out); end
        // Start coinciding with the result handshake.
        start = 1'b1;
        len = 8'd3;
        acc_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc_ready = 1'b0;
        total++; if (busy !== 1'b0 || p_ready !== 1'b0 || acc_valid !== 1'b0) begin bad++; $display("FAIL ign_done: busy=%b p_ready=%b acc_valid=%b want 0 0 0", busy, p_ready, acc_valid); end
        total++; if (acc_out !== 72'd30) begin bad++; $display("FAIL ign_retain: got %h want 1e", acc_out); end
        pulse_start(8'd1);
        send(-64'sd5, 0);
        total++; if (acc_valid !== 1'b1 || acc_out !== -72'sd5) begin bad++; $display("FAIL ign_next_start: acc_valid=%b acc_out=%h want 1 fffffffffffffffffb", acc_valid, acc_out); end
        handshake();
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        len = 8'd0;
        p_in = 64'd0;
        p_valid = 1'b0;
        acc_ready = 1'b0;
        test_reset();
        test_basic();
        test_gaps();
        test_len_zero();
        test_overflow();
        test_reset_mid();
        test_start_ignored();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the signed 32x32 multiplier's 64-bit product stream.
- Sums a programmed number of signed products into a wide accumulator (dot-product / MAC back end).
- Presents the result on a valid/ready output handshake.
- Sits between the multiplier output register and the result sink of the arithmetic chip.

Parameters:
- P_W, 64: product width (signed two's complement).
- ACC_W, 72: accumulator width; must be >= P_W.
- LEN_W, 8: width of the sequence length field (max LEN = 2^LEN_W - 1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  pulse; begins a new accumulation sequence. Sampled only in IDLE.
- len  input  LEN_W  number of products to accumulate. Sampled with start.
- p_in  input  P_W  signed product from the multiplier.
- p_valid  input  1  p_in is valid.
- p_ready  output  1  block accepts p_in this cycle.
- acc_out  output  ACC_W  signed accumulated result.
- acc_valid  output  1  acc_out holds the final sum.
- acc_ready  input  1  sink accepts acc_out.
- busy  output  1  high in ACCUM and DONE.
- overflow  output  1  sticky: signed overflow occurred in the current/last sequence.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; acc_out=0, acc_valid=0, p_ready=0, busy=0, overflow=0; internal count=0.
- FSM states: IDLE, ACCUM, DONE. All outputs are registered.
- IDLE, start=1, len!=0:
  - acc cleared to 0, overflow cleared, count loaded with len.
  - Next state ACCUM; p_ready=1 and busy=1 from the next cycle.
- IDLE, start=1, len==0:
  - acc=0, overflow=0, next state DONE.
  - acc_valid=1 on the next cycle; no products are consumed.
- ACCUM:
  - A transfer occurs on a cycle with p_valid=1 and p_ready=1.
  - On transfer: acc <= acc + sign_extend(p_in to ACC_W); count <= count-1.
  - Cycles with p_valid=0 hold all state; gaps of any length are allowed.
  - When the transfer with count==1 occurs: next state DONE; p_ready drops the following cycle.
  - acc_valid asserts exactly 1 cycle after the last accepted product.
- DONE:
  - acc_valid=1 and acc_out stable until acc_ready=1.
  - On acc_valid && acc_ready: next state IDLE; acc_valid=0 and busy=0 the next cycle.
  - acc_out retains its last value in IDLE.
- start outside IDLE is ignored, including in DONE on the handshake cycle. A new start is accepted from the first IDLE cycle onward.
- p_ready=0 outside ACCUM; p_valid in those states is ignored and no data is lost or consumed.
- Arithmetic:
  - Default ACC_W=72 gives 8 guard bits; no overflow is possible for len <= 255.
  - overflow sets when an addition's operands share a sign and the result sign differs. It stays set until the next accepted start.
- Reset mid-sequence: immediate return to IDLE with all outputs cleared; the partial sum is discarded.

Optional Feature:
- Macro: PRODUCT_ACC_SATURATE_EN.
- Defined: on a signed overflow the accumulator clamps to the most positive (0111..1) or most negative (1000..0) ACC_W value, and overflow is set. Subsequent additions continue from the clamped value with the same clamping.
- Undefined: the accumulator wraps modulo 2^ACC_W and overflow is still flagged.

Test Plan:
- len=4; products 1500, 2064, -345 (0xFFFFFFFFFFFFFEA7), -750 (0xFFFFFFFFFFFFFD12), one per cycle -> acc_valid 1 cycle after the 4th transfer; acc_out=2469 (0x9A5); overflow=0.
- Same stream with p_valid gaps of 0-3 cycles and acc_ready held low 5 cycles:
  - acc_out=2469; acc_valid is held with a stable value until acc_ready.
  - Exactly 4 transfers; a 5th p_valid pulse in DONE is not consumed.
- start with len=0 -> acc_valid next cycle; acc_out=0; p_ready never asserted.
- ACC_W=64; len=2; products 0x7FFFFFFFFFFFFFFF and 1:
  - Without the macro: acc_out=0x8000000000000000, overflow=1.
  - With PRODUCT_ACC_SATURATE_EN: acc_out=0x7FFFFFFFFFFFFFFF, overflow=1.
- Reset mid-ACCUM:
  - len=3, 1 product accepted, then rst=0 for 1 cycle -> all outputs 0, state IDLE.
  - New start with len=1 and product 2500 -> acc_out=2500, overflow=0.
- start asserted in ACCUM and again on the DONE handshake cycle -> both ignored; count and result unchanged; next start accepted in IDLE.
